next_pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined fetch stage. It owns the architectural PC and EPC registers and computes the next fetch address each cycle. Sources are sequential, PC-relative branch/jump, register-relative jump, exception vector entry and return-from-exception. A three-state control FSM (RUN, HANDLER, HALTED) adds a stall hold, halt latching and single-level exception tracking.

---
 rtl/next_pc_unit_if.sv | 37 +++
 rtl/next_pc_unit.sv | 124 ++++++++++++
 tb/tb_next_pc_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/next_pc_unit_if.sv
// Fetch-side port bundle for next_pc_unit.
// slave  : the PC unit (consumes control events, drives PC state outputs).
// master : the pipeline/controller driving events and observing PC state.
// Signals:
//   stall, redir_valid, redir_sel, imm_i, disp_d, rs_val, exc_req, rti, halt  (master -> slave)
//   pc, pc_plus, epc, in_handler, halted, err                                 (slave -> master)
interface next_pc_unit_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DISP_W = 11
);
    logic              stall;
    logic              redir_valid;
    logic [1:0]        redir_sel;
    logic [IMM_W-1:0]  imm_i;
    logic [DISP_W-1:0] disp_d;
    logic [WIDTH-1:0]  rs_val;
    logic              exc_req;
    logic              rti;
    logic              halt;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc_plus;
    logic [WIDTH-1:0]  epc;
    logic              in_handler;
    logic              halted;
    logic              err;

    modport slave (
        input  stall, redir_valid, redir_sel, imm_i, disp_d, rs_val, exc_req, rti, halt,
        output pc, pc_plus, epc, in_handler, halted, err
    );

    modport master (
        output stall, redir_valid, redir_sel, imm_i, disp_d, rs_val, exc_req, rti, halt,
        input  pc, pc_plus, epc, in_handler, halted, err
    );
endinterface

// File: rtl/next_pc_unit.sv
// Program-counter unit for the fetch stage. Holds PC and EPC, selects the next fetch
// address (sequential, PC-relative, register-relative, exception vector, return from
// exception) and tracks RUN / HANDLER / HALTED with a single-level exception state.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : next_pc_unit_if.slave (control events in, pc/pc_plus/epc/status out)
module next_pc_unit #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned IMM_W       = 8,
    parameter int unsigned DISP_W      = 11,
    parameter int unsigned INSTR_BYTES = 2,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned EXC_VECTOR  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    next_pc_unit_if.slave  bus
);

    typedef enum logic [1:0] {StRun, StHandler, StHalted} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] disp_sext;
    logic [WIDTH-1:0] redir_target;
    logic             redir_illegal;
    logic [WIDTH-1:0] flow_pc;
    logic             flow_err;

    assign pc_plus   = pc_q + WIDTH'(INSTR_BYTES);
    assign imm_sext  = {{(WIDTH-IMM_W){bus.imm_i[IMM_W-1]}}, bus.imm_i};
    assign disp_sext = {{(WIDTH-DISP_W){bus.disp_d[DISP_W-1]}}, bus.disp_d};

    always_comb begin
        redir_target  = pc_plus;
        redir_illegal = 1'b0;
        case (bus.redir_sel)
            2'b00:   redir_target = pc_plus + imm_sext;
            2'b01:   redir_target = pc_plus + disp_sext;
            2'b10:   redir_target = bus.rs_val + imm_sext;
            default: redir_illegal = 1'b1;  // reserved encoding falls through to sequential
        endcase
    end

    // Redirect-or-sequential outcome, shared by RUN and HANDLER.
    always_comb begin
        flow_pc  = pc_plus;
        flow_err = 1'b0;
        if (bus.redir_valid) begin
            flow_pc  = redir_target;
            flow_err = redir_illegal;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        err_d   = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                StRun: begin
                    if (bus.exc_req) begin
                        pc_d    = WIDTH'(EXC_VECTOR);
                        epc_d   = pc_plus;
                        state_d = StHandler;
                    end else if (bus.halt) begin
                        state_d = StHalted;
                    end else if (bus.rti) begin
                        pc_d  = pc_plus;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = flow_pc;
                        err_d = flow_err;
                    end
                end
                StHandler: begin
                    // No nesting: a new exception is flagged and the next event still runs.
                    if (bus.halt) begin
                        state_d = StHalted;
                    end else if (bus.rti) begin
                        pc_d    = epc_q;
                        state_d = StRun;
                    end else begin
                        pc_d  = flow_pc;
                        err_d = flow_err;
                    end
                    if (bus.exc_req) begin
                        err_d = 1'b1;
                    end
                end
                default: ;  // HALTED: frozen until reset
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            pc_q    <= WIDTH'(RESET_PC);
            epc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus    = pc_plus;
    assign bus.epc        = epc_q;
    assign bus.in_handler = (state_q == StHandler);
    assign bus.halted     = (state_q == StHalted);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with default parameters.
module tb_next_pc_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    next_pc_unit_if #(.WIDTH(16), .IMM_W(8), .DISP_W(11)) bus ();

    next_pc_unit #(
        .WIDTH(16), .IMM_W(8), .DISP_W(11), .INSTR_BYTES(2), .RESET_PC(0), .EXC_VECTOR(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall       = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_sel   = 2'b00;
        bus.imm_i       = '0;
        bus.disp_d      = '0;
        bus.rs_val      = '0;
        bus.exc_req     = 1'b0;
        bus.rti         = 1'b0;
        bus.halt        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load an absolute pc through the register-relative form with a zero immediate.
    task automatic set_pc(input logic [15:0] target);
        idle();
        bus.redir_valid = 1'b1;
        bus.redir_sel   = 2'b10;
        bus.rs_val      = target;
        tick();
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_pc", bus.pc, 32'h0000);
        check("rst_epc", bus.epc, 32'h0000);
        check("rst_err", bus.err, 32'h0);
        check("rst_in_handler", bus.in_handler, 32'h0);
        check("rst_halted", bus.halted, 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_pc", bus.pc, 32'h0000);
        check("pc_plus_comb", bus.pc_plus, 32'h0002);
        tick();
        check("seq_pc1", bus.pc, 32'h0002);
        tick();
        check("seq_pc2", bus.pc, 32'h0004);
        tick();
        check("seq_pc3", bus.pc, 32'h0006);
        check("seq_epc", bus.epc, 32'h0000);
        check("seq_err", bus.err, 32'h0);

        // Branch forms from pc=0x0010
        set_pc(16'h0010);
        check("setup_pc10", bus.pc, 32'h0010);
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b00; bus.imm_i = 8'hFE;
        tick(); idle();
        check("sel00_neg_imm", bus.pc, 32'h0010);
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b01; bus.disp_d = 11'h400;
        tick(); idle();
        // 0x400 is -1024 in 11 bits: 0x0012 + 0xFC00
        check("sel01_disp", bus.pc, 32'hFC12);
        set_pc(16'h0010);
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b10; bus.rs_val = 16'h1234; bus.imm_i = 8'h04;
        tick(); idle();
        check("sel10_reg", bus.pc, 32'h1238);
        set_pc(16'h0010);
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b11; bus.imm_i = 8'h40;
        tick(); idle();
        check("sel11_pc", bus.pc, 32'h0012);
        check("sel11_err", bus.err, 32'h1);
        tick();
        check("sel11_err_clear", bus.err, 32'h0);
        check("sel11_next_pc", bus.pc, 32'h0014);

        // Wrap-around
        set_pc(16'hFFFE);
        tick();
        check("wrap_seq", bus.pc, 32'h0000);
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b10; bus.rs_val = 16'hFFFF; bus.imm_i = 8'h01;
        tick(); idle();
        check("wrap_reg", bus.pc, 32'h0000);

        // Exception entry, nesting, return, stray rti
        set_pc(16'h0040);
        bus.exc_req = 1'b1;
        tick(); idle();
        check("exc_pc", bus.pc, 32'h0002);
        check("exc_epc", bus.epc, 32'h0042);
        check("exc_in_handler", bus.in_handler, 32'h1);
        check("exc_err", bus.err, 32'h0);
        bus.exc_req = 1'b1;
        tick(); idle();
        check("nest_err", bus.err, 32'h1);
        check("nest_pc", bus.pc, 32'h0004);
        check("nest_epc", bus.epc, 32'h0042);
        check("nest_in_handler", bus.in_handler, 32'h1);
        bus.rti = 1'b1;
        tick(); idle();
        check("rti_pc", bus.pc, 32'h0042);
        check("rti_in_handler", bus.in_handler, 32'h0);
        check("rti_err", bus.err, 32'h0);
        bus.rti = 1'b1;
        tick(); idle();
        check("rti_run_err", bus.err, 32'h1);
        check("rti_run_pc", bus.pc, 32'h0044);

        // Stall drops events, clears err
        bus.stall = 1'b1; bus.exc_req = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b10; bus.rs_val = 16'h0100;
        tick();
        check("stall_pc", bus.pc, 32'h0044);
        check("stall_epc", bus.epc, 32'h0042);
        check("stall_in_handler", bus.in_handler, 32'h0);
        check("stall_err", bus.err, 32'h0);
        bus.stall = 1'b0; bus.halt = 1'b1;
        tick(); idle();
        check("prio_pc", bus.pc, 32'h0002);
        check("prio_epc", bus.epc, 32'h0046);
        check("prio_in_handler", bus.in_handler, 32'h1);
        check("prio_halted", bus.halted, 32'h0);
        bus.exc_req = 1'b1; bus.rti = 1'b1;
        tick(); idle();
        check("exc_rti_pc", bus.pc, 32'h0046);
        check("exc_rti_err", bus.err, 32'h1);
        check("exc_rti_in_handler", bus.in_handler, 32'h0);

        // Halt and asynchronous reset
        set_pc(16'h0020);
        bus.halt = 1'b1;
        tick(); idle();
        check("halt_halted", bus.halted, 32'h1);
        check("halt_pc", bus.pc, 32'h0020);
        for (int i = 0; i < 5; i++) begin
            bus.redir_valid = 1'b1; bus.redir_sel = 2'b10; bus.rs_val = 16'h0300;
            bus.exc_req = 1'b1; bus.rti = 1'b1;
            tick();
        end
        idle();
        check("halted_pc_frozen", bus.pc, 32'h0020);
        check("halted_epc_frozen", bus.epc, 32'h0046);
        check("halted_err", bus.err, 32'h0);
        check("halted_still", bus.halted, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, 32'h0000);
        check("async_rst_halted", bus.halted, 32'h0);
        check("async_rst_epc", bus.epc, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("after_rst_seq", bus.pc, 32'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
